rfphoenix_alu_issue: RTL and testbench

Two-stage issue/retire sequencer that sits between decode/regfile-read and writeback in the rfPhoenix integer/FP-compare pipe. It takes decoded ops with operands over a valid/ready handshake and drives the team's combinational ALU from an operand register (S0). It captures the ALU result in a result register (S1) and presents it to writeback over a second valid/ready handshake. It forwards S1 results back into S0 operands and counts stall and retire events.

---
 rtl/rfphoenix_alu_issue_pkg.sv | 24 ++
 rtl/rfphoenix_satcnt.sv | 25 ++
 rtl/rfphoenix_alu_issue.sv | 136 +++++++++++++
 tb/tb_rfphoenix_alu_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_alu_issue_pkg.sv
// Shared types for the rfPhoenix ALU issue/retire sequencer.
package rfphoenix_alu_issue_pkg;

   typedef logic [31:0] Instruction;
   typedef logic [31:0] Value;

   localparam int REGW_DEF = 6;
   localparam int CNTW_DEF = 32;

   // Operand payload captured by S0; register tags live in the top because their width is a parameter.
   typedef struct packed {
      Instruction ir;
      Value       a;
      Value       b;
      Value       c;
      Value       t;
      Value       imm;
   } s0_ops_t;

   function automatic Value fwd_sel(input logic hit, input Value res, input Value opnd);
      return hit ? res : opnd;
   endfunction

endpackage

// File: rtl/rfphoenix_satcnt.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module rfphoenix_satcnt #(
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_i,
   output logic [CNTW-1:0] cnt_o
);

   logic [CNTW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rfphoenix_alu_issue.sv
// Two-stage issue/retire sequencer: S0 operand register feeds the external ALU,
// S1 result register feeds writeback, with S1->S0 operand forwarding.
module rfphoenix_alu_issue
   import rfphoenix_alu_issue_pkg::*;
#(
   parameter int REGW = REGW_DEF,
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_ir,
   input  logic [REGW-1:0] in_ra,
   input  logic [REGW-1:0] in_rb,
   input  logic [REGW-1:0] in_rc,
   input  logic [REGW-1:0] in_rt,
   input  logic [31:0]     in_a,
   input  logic [31:0]     in_b,
   input  logic [31:0]     in_c,
   input  logic [31:0]     in_t,
   input  logic [31:0]     in_imm,
   output logic [31:0]     alu_ir,
   output logic [31:0]     alu_a,
   output logic [31:0]     alu_b,
   output logic [31:0]     alu_c,
   output logic [31:0]     alu_t,
   output logic [31:0]     alu_imm,
   input  logic [31:0]     alu_o,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [REGW-1:0] wb_rt,
   output logic [31:0]     wb_res,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] retire_cnt
);

   typedef logic [REGW-1:0] Regspec;

   s0_ops_t s0_q, s0_d;
   Regspec  s0_ra_q, s0_ra_d, s0_rb_q, s0_rb_d, s0_rc_q, s0_rc_d, s0_rt_q, s0_rt_d;
   Regspec  wb_rt_q, wb_rt_d;
   Value    wb_res_q, wb_res_d;
   logic    s0_v_q, s0_v_d, s1_v_q, s1_v_d;
   logic    retire, adv, accept, rdy;
   logic    hit_a, hit_b, hit_c;

   assign retire = s1_v_q & wb_ready;
   assign adv    = s0_v_q & (~s1_v_q | wb_ready);
   assign rdy    = ~s0_v_q | adv;
   assign accept = in_valid & rdy;

   always_comb begin
      s0_d     = s0_q;
      s0_ra_d  = s0_ra_q;
      s0_rb_d  = s0_rb_q;
      s0_rc_d  = s0_rc_q;
      s0_rt_d  = s0_rt_q;
      wb_rt_d  = wb_rt_q;
      wb_res_d = wb_res_q;
      if (accept) begin
         s0_d    = '{ir: in_ir, a: in_a, b: in_b, c: in_c, t: in_t, imm: in_imm};
         s0_ra_d = in_ra;
         s0_rb_d = in_rb;
         s0_rc_d = in_rc;
         s0_rt_d = in_rt;
      end
      if (adv) begin
         wb_rt_d  = s0_rt_q;
         wb_res_d = alu_o;
      end
      s0_v_d = accept | (s0_v_q & ~adv);
      s1_v_d = adv | (s1_v_q & ~retire);
      // Flush wins over accept/adv; payload may still load but is never marked valid.
      if (flush) begin
         s0_v_d = 1'b0;
         s1_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q     <= '0;
         s0_ra_q  <= '0;
         s0_rb_q  <= '0;
         s0_rc_q  <= '0;
         s0_rt_q  <= '0;
         wb_rt_q  <= '0;
         wb_res_q <= '0;
         s0_v_q   <= 1'b0;
         s1_v_q   <= 1'b0;
      end else begin
         s0_q     <= s0_d;
         s0_ra_q  <= s0_ra_d;
         s0_rb_q  <= s0_rb_d;
         s0_rc_q  <= s0_rc_d;
         s0_rt_q  <= s0_rt_d;
         wb_rt_q  <= wb_rt_d;
         wb_res_q <= wb_res_d;
         s0_v_q   <= s0_v_d;
         s1_v_q   <= s1_v_d;
      end
   end

   // Tag 0 is "no write", so it never matches a producer.
   assign hit_a = s1_v_q && (s0_ra_q == wb_rt_q) && (wb_rt_q != '0);
   assign hit_b = s1_v_q && (s0_rb_q == wb_rt_q) && (wb_rt_q != '0);
   assign hit_c = s1_v_q && (s0_rc_q == wb_rt_q) && (wb_rt_q != '0);

   assign alu_ir   = s0_q.ir;
   assign alu_a    = fwd_sel(hit_a, wb_res_q, s0_q.a);
   assign alu_b    = fwd_sel(hit_b, wb_res_q, s0_q.b);
   assign alu_c    = fwd_sel(hit_c, wb_res_q, s0_q.c);
   assign alu_t    = s0_q.t;
   assign alu_imm  = s0_q.imm;
   assign in_ready = rdy;
   assign wb_valid = s1_v_q;
   assign wb_rt    = wb_rt_q;
   assign wb_res   = wb_res_q;

   rfphoenix_satcnt #(.CNTW(CNTW)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (in_valid & ~rdy),
      .cnt_o (stall_cnt)
   );

   rfphoenix_satcnt #(.CNTW(CNTW)) u_retire_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (retire),
      .cnt_o (retire_cnt)
   );

endmodule

// File: tb/tb_rfphoenix_alu_issue.sv
// Scoreboard bench for rfphoenix_alu_issue with a small behavioural ALU.
module tb_rfphoenix_alu_issue;

   localparam int REGW = 6;
   localparam int CNTW = 32;
   localparam logic [31:0] ADD = 32'd0, ADDI = 32'd1, ADDC = 32'd2;

   logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic            in_valid = 1'b0, in_ready;
   logic [31:0]     in_ir = '0, in_a = '0, in_b = '0, in_c = '0, in_t = '0, in_imm = '0;
   logic [REGW-1:0] in_ra = '0, in_rb = '0, in_rc = '0, in_rt = '0;
   logic [31:0]     alu_ir, alu_a, alu_b, alu_c, alu_t, alu_imm, alu_o;
   logic            wb_valid, wb_ready = 1'b1;
   logic [REGW-1:0] wb_rt;
   logic [31:0]     wb_res;
   logic [CNTW-1:0] stall_cnt, retire_cnt;
   logic            sc_inc = 1'b0;
   logic [2:0]      sc_cnt;

   int checks = 0, errors = 0, cyc = 0, n_ret = 0;

   typedef struct {
      logic [REGW-1:0] rt;
      logic [31:0]     res;
      int              cyc;
      int              lat;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment ALU: ADD a+b, ADDI a+imm, ADDC a+c.
   assign alu_o = (alu_ir == ADD)  ? alu_a + alu_b :
                  (alu_ir == ADDI) ? alu_a + alu_imm :
                  (alu_ir == ADDC) ? alu_a + alu_c : 32'd0;

   rfphoenix_alu_issue #(.REGW(REGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
      .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_rt(in_rt),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_t(in_t), .in_imm(in_imm),
      .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_t(alu_t), .alu_imm(alu_imm), .alu_o(alu_o),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rt(wb_rt), .wb_res(wb_res),
      .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
   );

   rfphoenix_satcnt #(.CNTW(3)) u_sc (.clk(clk), .rst_n(rst_n), .inc_i(sc_inc), .cnt_o(sc_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: pops on every writeback handshake and watches stability under backpressure.
   logic            hold_v = 1'b0;
   logic [REGW-1:0] hold_rt;
   logic [31:0]     hold_res;
   always @(negedge clk) begin
      if (rst_n && wb_valid && hold_v) begin
         chk("stable_rt", 32'(wb_rt), 32'(hold_rt));
         chk("stable_res", wb_res, hold_res);
      end
      hold_v   = rst_n && wb_valid && !wb_ready;
      hold_rt  = wb_rt;
      hold_res = wb_res;
      if (rst_n && wb_valid && wb_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_retire", wb_res, 32'hDEAD_BEEF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            n_ret++;
            chk("wb_rt", 32'(wb_rt), 32'(e.rt));
            chk("wb_res", wb_res, e.res);
            if (e.lat != 0) chk("latency", cyc - e.cyc, e.lat);
         end
      end
   end

   task automatic send(input logic [31:0] ir, input logic [REGW-1:0] ra, rb, rc, rt,
                       input logic [31:0] a, b, c, imm, exp_res, input bit push, input int lat);
      bit ok = 0;
      in_valid = 1'b1; in_ir = ir; in_ra = ra; in_rb = rb; in_rc = rc; in_rt = rt;
      in_a = a; in_b = b; in_c = c; in_t = 32'h5A5A; in_imm = imm;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      else if (push) sbq.push_back('{rt: rt, res: exp_res, cyc: cyc, lat: lat});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sbq.size() == 0 && !wb_valid) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", 32'(sbq.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rt", 32'(wb_rt), 32'd0);
      chk("rst_wb_res", wb_res, 32'd0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Back-to-back independent ADDs, 2-cycle latency.
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd1, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12, 1, 2);
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd2, 32'd1, 32'd2, 32'd0, 32'd0, 32'd3, 1, 2);
      drain();
      chk("retire_t1", retire_cnt, 32'd2);
      chk("stall_t1", stall_cnt, 32'd0);

      // Forwarding into a, b and c.
      send(ADDI, 6'd0, 6'd0, 6'd0, 6'd3, 32'd10, 32'd0, 32'd0, 32'd1, 32'd11, 1, 2);
      send(ADDI, 6'd3, 6'd0, 6'd0, 6'd4, 32'd0, 32'd0, 32'd0, 32'd4, 32'd15, 1, 2);
      send(ADD, 6'd9, 6'd4, 6'd0, 6'd5, 32'd100, 32'd0, 32'd0, 32'd0, 32'd115, 1, 2);
      send(ADDC, 6'd0, 6'd0, 6'd5, 6'd6, 32'd1, 32'd0, 32'd0, 32'd0, 32'd116, 1, 2);
      drain();

      // rt=0 never forwards.
      send(ADDI, 6'd0, 6'd0, 6'd0, 6'd0, 32'd10, 32'd0, 32'd0, 32'd1, 32'd11, 1, 2);
      send(ADDI, 6'd0, 6'd0, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 1, 2);
      drain();

      // Backpressure: three ops offered with wb_ready low.
      wb_ready = 1'b0;
      fork
         begin
            send(ADD, 6'd0, 6'd0, 6'd0, 6'd10, 32'd20, 32'd1, 32'd0, 32'd0, 32'd21, 1, 0);
            send(ADD, 6'd0, 6'd0, 6'd0, 6'd11, 32'd30, 32'd2, 32'd0, 32'd0, 32'd32, 1, 0);
            send(ADD, 6'd0, 6'd0, 6'd0, 6'd12, 32'd40, 32'd3, 32'd0, 32'd0, 32'd43, 1, 0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_rdy_low", 32'(in_ready), 32'd0);
            chk("bp_s1_res", wb_res, 32'd21);
            repeat (3) @(negedge clk);
            chk("bp_rdy_still_low", 32'(in_ready), 32'd0);
            chk("bp_stall_mid", stall_cnt, 32'd3);
            chk("bp_s1_hold", wb_res, 32'd21);
            @(posedge clk); #1 wb_ready = 1'b1;
         end
      join
      drain();
      chk("bp_stall_end", stall_cnt, 32'd4);

      // Flush in FULL; the retire during the flush cycle still counts, the op offered then is dropped.
      wb_ready = 1'b0;
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd13, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2, 1, 0);
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd14, 32'd2, 32'd2, 32'd0, 32'd0, 32'd4, 0, 0);
      @(negedge clk);
      chk("full_rdy_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b1; wb_ready = 1'b1;
      in_valid = 1'b1; in_ir = ADD; in_rt = 6'd15; in_a = 32'd77; in_b = 32'd0;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("flush_wb_valid", 32'(wb_valid), 32'd0);
      end
      @(posedge clk); #1;
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd16, 32'd8, 32'd9, 32'd0, 32'd0, 32'd17, 1, 2);
      drain();
      chk("retire_total", retire_cnt, 32'(n_ret));
      chk("retire_const", retire_cnt, 32'd13);
      chk("stall_after_flush", stall_cnt, 32'd4);

      // Saturating counter stops at all-ones.
      @(posedge clk); #1 sc_inc = 1'b1;
      repeat (10) @(posedge clk);
      #1 sc_inc = 1'b0;
      chk("sat_cnt", 32'(sc_cnt), 32'd7);

      // Mid-stream asynchronous reset.
      wb_ready = 1'b0;
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd20, 32'd3, 32'd3, 32'd0, 32'd0, 32'd6, 0, 0);
      send(ADD, 6'd0, 6'd0, 6'd0, 6'd21, 32'd4, 32'd4, 32'd0, 32'd0, 32'd8, 0, 0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(wb_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_wb_valid", 32'(wb_valid), 32'd0);
      chk("async_stall", stall_cnt, 32'd0);
      chk("async_retire", retire_cnt, 32'd0);
      chk("async_wb_res", wb_res, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1; wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
      end
      chk("post_rst_rdy", 32'(in_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
